// File: rtl/scan_pkg.sv
// Shared types and constants for the scan sequencer.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
package scan_pkg;

    localparam int NUM_CH      = 8;
    localparam int SEL_W       = 3;
    localparam int DWELL_W_DEF = 8;

    // GAP is only ever entered when the build enables blanking.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Index of the lowest set bit; returns 0 for an empty mask (callers
    // never use the result in that case).
    function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
        lowest_set = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = SEL_W'(i);
        end
    endfunction

endpackage

// File: rtl/scan_next_ch.sv
// Finds the next enabled channel strictly above cur, wrapping to the lowest enabled one.
// Latency: purely combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module scan_next_ch
    import scan_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    output logic [SEL_W-1:0]  nxt,
    output logic              wrap
);

    // Walk the offsets from farthest to nearest so the nearest set bit wins;
    // if no other bit is set the current channel is reused (single-channel mask).
    always_comb begin
        nxt = cur;
        for (int i = NUM_CH - 1; i >= 1; i--) begin
            if (mask[cur + SEL_W'(i)]) nxt = cur + SEL_W'(i);
        end
        wrap = (nxt <= cur);
    end

endmodule

// File: rtl/scan_sequencer.sv
// Sweeps a 3-bit select across masked channels with programmable dwell; optional one-cycle blanking via SCAN_BLANK_EN.
// Latency: start sampled at edge t gives sel/en after edge t; all outputs registered.
// Backpressure: none; start is ignored while busy, stop aborts at the next edge without done.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NUM_CH-1:0]  mask,
    output logic [SEL_W-1:0]   sel,
    output logic               en,
    output logic               busy,
    output logic               done
);

    state_t              state_q, state_d;
    logic [DWELL_W-1:0]  cnt_q, cnt_d;
    logic [DWELL_W-1:0]  dlast_q, dlast_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic                cont_q, cont_d;
    logic [SEL_W-1:0]    sel_d;
    logic                en_d, busy_d, done_d;

    logic [SEL_W-1:0]    nxt;
    logic                wrap;

    scan_next_ch u_next_ch (
        .mask (mask_q),
        .cur  (sel),
        .nxt  (nxt),
        .wrap (wrap)
    );

    // Next-state and next-output logic; done is a pulse so it defaults low.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dlast_d = dlast_q;
        mask_d  = mask_q;
        cont_d  = cont_q;
        sel_d   = sel;
        en_d    = en;
        busy_d  = busy;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop && (mask != '0)) begin
                    mask_d  = mask;
                    cont_d  = cont;
                    // Store D-1 so the last dwell cycle is a plain compare; 0 acts as 1.
                    dlast_d = (dwell == '0) ? '0 : dwell - 1'b1;
                    cnt_d   = '0;
                    sel_d   = lowest_set(mask);
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end

            SCAN: begin
                if (stop) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end else if (cnt_q == dlast_q) begin
                    cnt_d = '0;
                    if (wrap && !cont_q) begin
                        state_d = IDLE;
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        sel_d  = nxt;
                        done_d = wrap;
`ifdef SCAN_BLANK_EN
                        // Blank for one cycle with the new code already on sel.
                        state_d = GAP;
                        en_d    = 1'b0;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

`ifdef SCAN_BLANK_EN
            GAP: begin
                if (stop) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    state_d = SCAN;
                    en_d    = 1'b1;
                end
            end
`endif

            default: begin
                state_d = IDLE;
                en_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, config and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dlast_q <= '0;
            mask_q  <= '0;
            cont_q  <= 1'b0;
            sel     <= '0;
            en      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dlast_q <= dlast_d;
            mask_q  <= mask_d;
            cont_q  <= cont_d;
            sel     <= sel_d;
            en      <= en_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Self-checking bench for scan_sequencer: directed table, corner sequences, random traces vs a trace model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
`timescale 1ns/1ps
module tb_scan_sequencer;

    localparam int DW = 8;
`ifdef SCAN_BLANK_EN
    localparam int B = 1;
`else
    localparam int B = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          cont = 1'b0;
    logic [DW-1:0] dwell = '0;
    logic [7:0]    mask = '0;
    logic [2:0]    sel;
    logic          en, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    scan_sequencer #(.DWELL_W(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .cont  (cont),
        .dwell (dwell),
        .mask  (mask),
        .sel   (sel),
        .en    (en),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] sel;
        logic       en;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct {
        logic [7:0] mask;
        int         dwell;
        int         done_at;
        int         first_sel;
    } vec_t;

    obs_t exp_q[$];

    function automatic obs_t mk(input int s, input bit e, input bit b, input bit d);
        obs_t o;
        o.sel  = 3'(s);
        o.en   = e;
        o.busy = b;
        o.done = d;
        return o;
    endfunction

    task automatic check_obs(input string name, input int cyc, input obs_t exp);
        obs_t act;
        act = {sel, en, busy, done};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got sel=%0d en=%0b busy=%0b done=%0b, expected sel=%0d en=%0b busy=%0b done=%0b",
                     name, cyc, act.sel, act.en, act.busy, act.done, exp.sel, exp.en, exp.busy, exp.done);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Trace model: lay out the sweep channel by channel, then apply the stop rule.
    task automatic build_exp(input logic [7:0] m, input int d, input bit c, input int total, input int ks);
        int   chs[$];
        int   dd;
        bit   first;
        obs_t hold;
        dd    = (d == 0) ? 1 : d;
        first = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 8; i++) if (m[i]) chs.push_back(i);
        while (exp_q.size() < total) begin
            for (int j = 0; j < chs.size(); j++) begin
`ifdef SCAN_BLANK_EN
                if (!(first && j == 0)) exp_q.push_back(mk(chs[j], 1'b0, 1'b1, j == 0));
                for (int k = 0; k < dd; k++) exp_q.push_back(mk(chs[j], 1'b1, 1'b1, 1'b0));
`else
                for (int k = 0; k < dd; k++)
                    exp_q.push_back(mk(chs[j], 1'b1, 1'b1, !first && j == 0 && k == 0));
`endif
            end
            first = 1'b0;
            if (!c) begin
                exp_q.push_back(mk(chs[chs.size()-1], 1'b0, 1'b0, 1'b1));
                while (exp_q.size() < total) exp_q.push_back(mk(chs[chs.size()-1], 1'b0, 1'b0, 1'b0));
            end
        end
        if (ks >= 0 && ks < exp_q.size() - 1 && exp_q[ks].busy) begin
            hold = exp_q[ks];
            for (int i = ks + 1; i < exp_q.size(); i++) exp_q[i] = mk(hold.sel, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Start a scan, scramble the inputs afterwards (they must be latched), compare every cycle.
    task automatic run_trace(input string name, input logic [7:0] m, input int d, input bit c,
                             input int total, input int ks);
        build_exp(m, d, c, total, ks);
        @(negedge clk);
        mask  = m;
        dwell = DW'(d);
        cont  = c;
        start = 1'b1;
        stop  = 1'b0;
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            check_obs(name, i, exp_q[i]);
            start = 1'b0;
            stop  = (i == ks);
            if (i == 0) begin
                mask  = 8'($urandom);
                dwell = DW'($urandom);
                cont  = 1'($urandom);
            end
        end
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        vec_t vecs[7];
        int   seen, ndone, busy_at_done, cyc_cnt;
        obs_t first_obs;

        vecs[0] = '{8'hA5, 3, 12 + 3*B, 0};
        vecs[1] = '{8'h10, 0, 1,        4};
        vecs[2] = '{8'h03, 2, 4 + 1*B,  0};
        vecs[3] = '{8'h80, 5, 5,        7};
        vecs[4] = '{8'hFF, 1, 8 + 7*B,  0};
        vecs[5] = '{8'h81, 0, 2 + 1*B,  0};
        vecs[6] = '{8'h42, 4, 8 + 1*B,  1};

        // Reset state.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_obs("reset", 0, mk(0, 0, 0, 0));
        rst = 1'b0;

        // Start with an empty mask is ignored.
        @(negedge clk);
        mask  = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_obs("empty_mask", i, mk(0, 0, 0, 0));
            @(negedge clk);
        end

        // Start and stop together: stop wins.
        mask  = 8'h05;
        dwell = 8'd2;
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_obs("start_stop", i, mk(0, 0, 0, 0));
            @(negedge clk);
        end

        // Single-sweep table: done position, first channel, busy drop, single done pulse.
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            mask  = vecs[v].mask;
            dwell = DW'(vecs[v].dwell);
            cont  = 1'b0;
            start = 1'b1;
            seen  = -1;
            ndone = 0;
            busy_at_done = 1;
            for (int i = 0; i < 64; i++) begin
                @(negedge clk);
                start = 1'b0;
                if (i == 0) first_obs = {sel, en, busy, done};
                if (done) begin
                    ndone++;
                    if (seen < 0) begin
                        seen = i;
                        busy_at_done = busy;
                    end
                end
            end
            check_int($sformatf("tbl%0d_done_at", v), seen, vecs[v].done_at);
            check_int($sformatf("tbl%0d_first_sel", v), first_obs.sel, vecs[v].first_sel);
            check_int($sformatf("tbl%0d_first_en", v), first_obs.en, 1);
            check_int($sformatf("tbl%0d_busy_at_done", v), busy_at_done, 0);
            check_int($sformatf("tbl%0d_done_count", v), ndone, 1);
        end

        // Test-plan traces.
        run_trace("a5_single", 8'hA5, 3, 1'b0, 20, -1);
        run_trace("single_ch_cont", 8'h10, 0, 1'b1, 10, 5);
        run_trace("ff_stop_last", 8'hFF, 2, 1'b1, 7*(2+B) + 6, 7*(2+B) + 1);
        run_trace("blank_pair", 8'h03, 2, 1'b0, 8, -1);

        // Reset in the middle of channel 3's dwell.
        @(negedge clk);
        mask  = 8'hFF;
        dwell = 8'd4;
        cont  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3*(4+B) + 1) @(negedge clk);
        check_int("pre_reset_sel", sel, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_obs("mid_reset", 0, mk(0, 0, 0, 0));
        run_trace("after_reset", 8'h24, 1, 1'b0, 8, -1);

        // A new start in the cycle where done is high is accepted.
        @(negedge clk);
        mask  = 8'hA5;
        dwell = 8'd1;
        cont  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        cyc_cnt = 0;
        while (!done && cyc_cnt < 40) begin
            @(negedge clk);
            cyc_cnt++;
        end
        check_int("done_seen", done, 1);
        mask  = 8'h08;
        dwell = 8'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_obs("restart_in_done", 0, mk(3, 1, 1, 0));
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;

        // Random traces against the model.
        for (int r = 0; r < 30; r++) begin
            logic [7:0] rm;
            int rd, tot, ks, nch;
            bit rc;
            rm  = 8'($urandom_range(1, 255));
            rd  = $urandom_range(0, 4);
            rc  = 1'($urandom);
            nch = $countones(rm);
            tot = rc ? 40 : nch * (((rd == 0) ? 1 : rd) + B) + 4;
            ks  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, tot - 2)) : -1;
            run_trace($sformatf("rand%0d", r), rm, rd, rc, tot, ks);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
